// File: rtl/nand_seq_pkg.sv
// Shared types and default timing for the NAND command/address sequencer.
package nand_seq_pkg;

  localparam int unsigned MAX_ADDR_BYTES = 5;
  localparam int unsigned DEF_TMR_W      = 10;
  localparam int unsigned DEF_T_CS       = 2;
  localparam int unsigned DEF_T_WP       = 3;
  localparam int unsigned DEF_T_WH       = 2;
  localparam int unsigned DEF_T_WB       = 5;
  localparam int unsigned DEF_T_RB_TO    = 1000;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CS,
    ST_CMD_WP,
    ST_CMD_WH,
    ST_ADDR_WP,
    ST_ADDR_WH,
    ST_RB_WB,
    ST_RB_POLL,
    ST_DONE
  } seq_state_e;

  typedef struct packed {
    logic ce_n;
    logic cle;
    logic ale;
    logic we_n;
    logic dq_oe;
  } pin_ctl_t;

  localparam pin_ctl_t PIN_CTL_IDLE = '{ce_n: 1'b1, cle: 1'b0, ale: 1'b0, we_n: 1'b1, dq_oe: 1'b0};

  function automatic logic [2:0] clamp_cnt(input logic [2:0] cnt);
    return (cnt > 3'(MAX_ADDR_BYTES)) ? 3'(MAX_ADDR_BYTES) : cnt;
  endfunction

endpackage

// File: rtl/nand_rb_sync.sv
// Two-flop synchronizer for the device R/B# pin; resets to ready.
module nand_rb_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rb_n_i,
  output logic rb_n_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= rb_n_i;
      sync_q <= meta_q;
    end
  end

  assign rb_n_o = sync_q;

endmodule

// File: rtl/nand_cmd_seq.sv
// NAND command/address sequencer: one command byte, 0-5 address bytes, optional R/B# wait,
// with every phase width measured by the external shared timer.
module nand_cmd_seq
  import nand_seq_pkg::*;
#(
  parameter int unsigned TMR_W   = DEF_TMR_W,
  parameter int unsigned T_CS    = DEF_T_CS,
  parameter int unsigned T_WP    = DEF_T_WP,
  parameter int unsigned T_WH    = DEF_T_WH,
  parameter int unsigned T_WB    = DEF_T_WB,
  parameter int unsigned T_RB_TO = DEF_T_RB_TO
) (
  input  logic             cpld_50m_clk,
  input  logic             cpld_rst_50m,
  input  logic             op_start,
  input  logic [7:0]       op_cmd,
  input  logic [39:0]      op_addr,
  input  logic [2:0]       op_addr_cnt,
  input  logic             op_wait_rb,
  output logic             op_busy,
  output logic             op_done,
  output logic             op_err,
  output logic             nand_ce_n,
  output logic             nand_cle,
  output logic             nand_ale,
  output logic             nand_we_n,
  output logic [7:0]       nand_dq_out,
  output logic             nand_dq_oe,
  input  logic             nand_rb_n,
  output logic             tmr_en,
  output logic [TMR_W-1:0] tmr_dly,
  input  logic             tmr_timeout
);

  seq_state_e       state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [39:0]      addr_q, addr_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             wait_q, wait_d;
  logic             err_q, err_d;

  pin_ctl_t         ctl_q, ctl_d;
  logic [7:0]       dq_q, dq_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             en_q, en_d;
  logic             en_prev_q;
  logic [TMR_W-1:0] dly_q, dly_d;

  logic             rb_ready;
  logic             phase_end;
  seq_state_e       after_bytes;

  nand_rb_sync u_rb_sync (
    .clk_i  (cpld_50m_clk),
    .rst_i  (cpld_rst_50m),
    .rb_n_i (nand_rb_n),
    .rb_n_o (rb_ready)
  );

  // A timeout only counts once the timer has been running, so a stale expiry is never taken.
  assign phase_end   = tmr_timeout && en_q && en_prev_q;
  assign after_bytes = wait_q ? ST_RB_WB : ST_DONE;

  always_ff @(posedge cpld_50m_clk or posedge cpld_rst_50m) begin
    if (cpld_rst_50m) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      wait_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (op_start) begin
          cmd_d   = op_cmd;
          addr_d  = op_addr;
          cnt_d   = clamp_cnt(op_addr_cnt);
          wait_d  = op_wait_rb;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = ST_CS;
        end
      end
      ST_CS:      if (phase_end) state_d = ST_CMD_WP;
      ST_CMD_WP:  if (phase_end) state_d = ST_CMD_WH;
      ST_CMD_WH:  if (phase_end) state_d = (cnt_q != 3'd0) ? ST_ADDR_WP : after_bytes;
      ST_ADDR_WP: if (phase_end) state_d = ST_ADDR_WH;
      ST_ADDR_WH: begin
        if (phase_end) begin
          if (idx_q == 3'(cnt_q - 3'd1)) begin
            state_d = after_bytes;
          end else begin
            idx_d   = 3'(idx_q + 3'd1);
            state_d = ST_ADDR_WP;
          end
        end
      end
      ST_RB_WB:   if (phase_end) state_d = ST_RB_POLL;
      ST_RB_POLL: begin
        if (rb_ready) begin
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (phase_end) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Pin and timer values are decoded from the upcoming state so they register alongside it.
  always_comb begin
    logic timed;
    timed  = 1'b0;
    ctl_d  = PIN_CTL_IDLE;
    dq_d   = '0;
    busy_d = 1'b0;
    done_d = 1'b0;
    dly_d  = dly_q;
    case (state_d)
      ST_CS: begin
        ctl_d.ce_n = 1'b0;
        busy_d     = 1'b1;
        timed      = 1'b1;
        dly_d      = TMR_W'(T_CS);
      end
      ST_CMD_WP, ST_CMD_WH: begin
        ctl_d.ce_n  = 1'b0;
        ctl_d.cle   = 1'b1;
        ctl_d.dq_oe = 1'b1;
        ctl_d.we_n  = (state_d == ST_CMD_WH);
        dq_d        = cmd_d;
        busy_d      = 1'b1;
        timed       = 1'b1;
        dly_d       = (state_d == ST_CMD_WP) ? TMR_W'(T_WP) : TMR_W'(T_WH);
      end
      ST_ADDR_WP, ST_ADDR_WH: begin
        ctl_d.ce_n  = 1'b0;
        ctl_d.ale   = 1'b1;
        ctl_d.dq_oe = 1'b1;
        ctl_d.we_n  = (state_d == ST_ADDR_WH);
        dq_d        = addr_d[{idx_d, 3'b000} +: 8];
        busy_d      = 1'b1;
        timed       = 1'b1;
        dly_d       = (state_d == ST_ADDR_WP) ? TMR_W'(T_WP) : TMR_W'(T_WH);
      end
      ST_RB_WB, ST_RB_POLL: begin
        ctl_d.ce_n = 1'b0;
        busy_d     = 1'b1;
        timed      = 1'b1;
        dly_d      = (state_d == ST_RB_WB) ? TMR_W'(T_WB) : TMR_W'(T_RB_TO);
      end
      ST_DONE:  done_d = 1'b1;
      default:  ;
    endcase
    en_d = timed && (state_d == state_q);
  end

  always_ff @(posedge cpld_50m_clk or posedge cpld_rst_50m) begin
    if (cpld_rst_50m) begin
      ctl_q     <= PIN_CTL_IDLE;
      dq_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      en_q      <= 1'b0;
      en_prev_q <= 1'b0;
      dly_q     <= '0;
    end else begin
      ctl_q     <= ctl_d;
      dq_q      <= dq_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      en_q      <= en_d;
      en_prev_q <= en_q;
      dly_q     <= dly_d;
    end
  end

  assign op_busy     = busy_q;
  assign op_done     = done_q;
  assign op_err      = err_q;
  assign nand_ce_n   = ctl_q.ce_n;
  assign nand_cle    = ctl_q.cle;
  assign nand_ale    = ctl_q.ale;
  assign nand_we_n   = ctl_q.we_n;
  assign nand_dq_oe  = ctl_q.dq_oe;
  assign nand_dq_out = dq_q;
  assign tmr_en      = en_q;
  assign tmr_dly     = dly_q;

endmodule

// File: tb/tb_nand_cmd_seq.sv
// Self-checking bench: expected pin waveforms are built phase by phase from the timing rules.
module tb_nand_cmd_seq;

  localparam int unsigned TMR_W   = 10;
  localparam int unsigned T_CS    = 2;
  localparam int unsigned T_WP    = 3;
  localparam int unsigned T_WH    = 2;
  localparam int unsigned T_WB    = 5;
  localparam int unsigned T_RB_TO = 100;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             op_start = 1'b0;
  logic [7:0]       op_cmd = '0;
  logic [39:0]      op_addr = '0;
  logic [2:0]       op_addr_cnt = '0;
  logic             op_wait_rb = 1'b0;
  logic             op_busy, op_done, op_err;
  logic             nand_ce_n, nand_cle, nand_ale, nand_we_n, nand_dq_oe;
  logic [7:0]       nand_dq_out;
  logic             nand_rb_n = 1'b1;
  logic             tmr_en;
  logic [TMR_W-1:0] tmr_dly;
  logic             tmr_timeout;

  logic [TMR_W-1:0] tcnt;
  int               checks = 0;
  int               errors = 0;
  logic [14:0]      exp_q[$];

  always #10 clk = ~clk;

  nand_cmd_seq #(
    .TMR_W(TMR_W), .T_CS(T_CS), .T_WP(T_WP), .T_WH(T_WH), .T_WB(T_WB), .T_RB_TO(T_RB_TO)
  ) dut (
    .cpld_50m_clk(clk),       .cpld_rst_50m(rst),
    .op_start(op_start),      .op_cmd(op_cmd),         .op_addr(op_addr),
    .op_addr_cnt(op_addr_cnt), .op_wait_rb(op_wait_rb),
    .op_busy(op_busy),        .op_done(op_done),       .op_err(op_err),
    .nand_ce_n(nand_ce_n),    .nand_cle(nand_cle),     .nand_ale(nand_ale),
    .nand_we_n(nand_we_n),    .nand_dq_out(nand_dq_out), .nand_dq_oe(nand_dq_oe),
    .nand_rb_n(nand_rb_n),
    .tmr_en(tmr_en),          .tmr_dly(tmr_dly),       .tmr_timeout(tmr_timeout)
  );

  // Shared timer with tick held at 1: cleared while disabled, expires once it reaches dly.
  always @(posedge clk or posedge rst) begin
    if (rst)                tcnt <= '0;
    else if (!tmr_en)       tcnt <= '0;
    else if (tcnt != tmr_dly) tcnt <= tcnt + 1'b1;
  end
  assign tmr_timeout = tmr_en && (tcnt == tmr_dly);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] pins();
    return {op_busy, op_done, nand_ce_n, nand_cle, nand_ale, nand_we_n, nand_dq_oe,
            nand_dq_oe ? nand_dq_out : 8'h00};
  endfunction

  function automatic logic [14:0] pv(input logic busy, input logic done, input logic ce_n,
                                     input logic cle, input logic ale, input logic we_n,
                                     input logic oe, input logic [7:0] dq);
    return {busy, done, ce_n, cle, ale, we_n, oe, dq};
  endfunction

  task automatic add(input int n, input logic [14:0] v);
    for (int k = 0; k < n; k++) exp_q.push_back(v);
  endtask

  // Expected per-cycle pins from the cycle after the accepting edge through one idle cycle.
  task automatic build(input logic [7:0] cmd, input logic [39:0] addr, input int cnt,
                       input logic wait_rb, input logic rb_ready);
    int          n;
    logic [39:0] a;
    n = (cnt > 5) ? 5 : cnt;
    a = addr;
    exp_q.delete();
    add(int'(T_CS) + 2, pv(1, 0, 0, 0, 0, 1, 0, 8'h00));
    add(int'(T_WP) + 2, pv(1, 0, 0, 1, 0, 0, 1, cmd));
    add(int'(T_WH) + 2, pv(1, 0, 0, 1, 0, 1, 1, cmd));
    for (int i = 0; i < n; i++) begin
      add(int'(T_WP) + 2, pv(1, 0, 0, 0, 1, 0, 1, a[7:0]));
      add(int'(T_WH) + 2, pv(1, 0, 0, 0, 1, 1, 1, a[7:0]));
      a = a >> 8;
    end
    if (wait_rb) begin
      add(int'(T_WB) + 2, pv(1, 0, 0, 0, 0, 1, 0, 8'h00));
      add(rb_ready ? 1 : int'(T_RB_TO) + 2, pv(1, 0, 0, 0, 0, 1, 0, 8'h00));
    end
    add(1, pv(0, 1, 1, 0, 0, 1, 0, 8'h00));
    add(1, pv(0, 0, 1, 0, 0, 1, 0, 8'h00));
  endtask

  task automatic start_op(input logic [7:0] c, input logic [39:0] a, input logic [2:0] n,
                          input logic w);
    @(negedge clk);
    op_cmd = c; op_addr = a; op_addr_cnt = n; op_wait_rb = w; op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
  endtask

  task automatic cmp_trace(input int first, input int last, input int inject, input logic exp_err);
    for (int i = first; i <= last; i++) begin
      if (i > first) @(negedge clk);
      check("pins", 32'(pins()), 32'(exp_q[i]));
      if (i == 0) check("err_clear", 32'(op_err), 32'd0);
      else if (i >= exp_q.size() - 2) check("err", 32'(op_err), 32'(exp_err));
      if (i == inject) begin
        op_start = 1'b1; op_cmd = ~op_cmd; op_addr_cnt = 3'd0;
      end else begin
        op_start = 1'b0;
      end
    end
  endtask

  task automatic run_op(input logic [7:0] c, input logic [39:0] a, input logic [2:0] n,
                        input logic w, input logic rb, input int inject);
    build(c, a, int'(n), w, rb);
    start_op(c, a, n, w);
    cmp_trace(0, exp_q.size() - 1, inject, w && !rb);
  endtask

  task automatic set_rb(input logic rb);
    nand_rb_n = rb;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0]  rc;
    logic [39:0] ra;
    logic [2:0]  rn;
    logic        rw, rr;

    repeat (2) @(negedge clk);
    check("rst_pins", 32'(pins()), 32'(pv(0, 0, 1, 0, 0, 1, 0, 8'h00)));
    check("rst_dq", 32'(nand_dq_out), 32'd0);
    check("rst_tmr_en", 32'(tmr_en), 32'd0);
    check("rst_tmr_dly", 32'(tmr_dly), 32'd0);
    check("rst_err", 32'(op_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_pins", 32'(pins()), 32'(pv(0, 0, 1, 0, 0, 1, 0, 8'h00)));

    run_op(8'hFF, 40'h0, 3'd0, 1'b0, 1'b1, -1);
    run_op(8'h00, 40'h04_0302_0100, 3'd5, 1'b0, 1'b1, -1);

    set_rb(1'b0);
    run_op(8'h70, 40'h00_0000_BEEF, 3'd2, 1'b1, 1'b0, -1);
    check("err_held", 32'(op_err), 32'd1);

    // R/B# released 20 cycles into the poll phase.
    build(8'h71, 40'h0, 0, 1'b1, 1'b0);
    start_op(8'h71, 40'h0, 3'd0, 1'b1);
    cmp_trace(0, 40, -1, 1'b0);
    nand_rb_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("rel_done", 32'(op_done), (k == 3) ? 32'd1 : 32'd0);
      check("rel_busy", 32'(op_busy), (k == 3) ? 32'd0 : 32'd1);
    end
    check("rel_err", 32'(op_err), 32'd0);
    @(negedge clk);
    check("rel_idle", 32'(pins()), 32'(pv(0, 0, 1, 0, 0, 1, 0, 8'h00)));

    run_op(8'h80, 40'hAA_BBCC_DDEE, 3'd7, 1'b0, 1'b1, 10);
    run_op(8'h81, 40'h11_2233_4455, 3'd6, 1'b0, 1'b1, 40);

    // Reset in the middle of the third address byte.
    build(8'h90, 40'h55_6677_8899, 5, 1'b0, 1'b1);
    start_op(8'h90, 40'h55_6677_8899, 3'd5, 1'b0);
    cmp_trace(0, 33, -1, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_pins", 32'(pins()), 32'(pv(0, 0, 1, 0, 0, 1, 0, 8'h00)));
    check("mid_rst_tmr_en", 32'(tmr_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(8'hFF, 40'h0, 3'd0, 1'b0, 1'b1, -1);

    for (int t = 0; t < 8; t++) begin
      rc = 8'($urandom);
      ra = {8'($urandom), 32'($urandom)};
      rn = 3'($urandom_range(0, 7));
      rw = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      set_rb(rr);
      run_op(rc, ra, rn, rw, rr, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
